// File: rtl/com_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : com_bus_arb_pkg
//  Purpose  : Shared types, defaults and helpers for the round-robin common
//             bus arbiter (proc FSM state encoding, default channel counts,
//             one-hot to index conversion).
//  Revision : 1.0 - initial release
// ============================================================================
package com_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int c_DEF_NUM_PROC  = 8;
    localparam int c_DEF_NUM_SNOOP = 4;

    // Widest channel count supported by either arbitration side.
    localparam int c_MAX_CH    = 16;
    localparam int c_MAX_IDX_W = 4;

    // Index of the set bit of a one-hot vector (0 when the vector is zero).
    function automatic logic [c_MAX_IDX_W-1:0] onehot_to_idx(input logic [c_MAX_CH-1:0] oh);
        logic [c_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < c_MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | c_MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/com_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin pick. Grants the first set request
//             at or after ptr, wrapping modulo WIDTH.
//  Ports    : req   - request vector
//             ptr   - search start index (must be < WIDTH)
//             gnt   - one-hot pick, zero when no request
//             valid - at least one request is set
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int WIDTH = 8,
    parameter int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [WIDTH-1:0] gnt,
    output logic             valid
);

    // Walk WIDTH positions starting at ptr; the extra sum bit lets the
    // wrap be a single subtract even for non-power-of-two widths.
    always_comb begin
        logic [PTR_W:0] w_pos;
        logic           w_found;
        gnt     = '0;
        w_pos   = '0;
        w_found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pos = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (w_pos >= (PTR_W + 1)'(WIDTH)) begin
                w_pos = w_pos - (PTR_W + 1)'(WIDTH);
            end
            if (!w_found && req[w_pos[PTR_W-1:0]]) begin
                gnt[w_pos[PTR_W-1:0]] = 1'b1;
                w_found               = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/com_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : com_bus_arbiter_rr
//  Purpose  : Round-robin common-bus arbiter for NUM_PROC processors. While a
//             processor owns the bus, the snoop slot is arbitrated between
//             NUM_SNOOP caches (round-robin, priority) and lower-level memory.
//  Ports    : clk, rst (async, active-high)
//             Com_Bus_Req_proc / Com_Bus_Gnt_proc   - processor channels
//             Com_Bus_Req_snoop / Com_Bus_Gnt_snoop - cache snoop channels
//             Mem_snoop_req / Mem_snoop_gnt         - memory snoop slot
//             Arb_busy    - FSM not idle (grant or release dead cycle)
//             Arb_timeout - one-cycle pulse on forced release
//  Options  : `define ARB_TIMEOUT_EN enables the MAX_HOLD grant limit;
//             otherwise Arb_timeout is tied 0 and grants are held forever.
//  Revision : 1.0 - initial release
// ============================================================================
module com_bus_arbiter_rr
    import com_bus_arb_pkg::*;
#(
    parameter int NUM_PROC  = c_DEF_NUM_PROC,
    parameter int NUM_SNOOP = c_DEF_NUM_SNOOP,
    parameter int MAX_HOLD  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
    output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
    input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
    output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
    input  logic                 Mem_snoop_req,
    output logic                 Mem_snoop_gnt,
    output logic                 Arb_busy,
    output logic                 Arb_timeout
);

    localparam int c_PROC_W = $clog2(NUM_PROC);
    localparam int c_SNP_W  = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;

    if (NUM_PROC < 2 || NUM_PROC > c_MAX_CH || NUM_SNOOP < 1 ||
        NUM_SNOOP > c_MAX_CH || MAX_HOLD < 1) begin : g_param_check
        $error("com_bus_arbiter_rr: parameter out of range");
    end

    arb_state_t            r_state, w_state_nxt;
    arb_state_t            r_snp_state, w_snp_state_nxt;
    logic [c_PROC_W-1:0]   r_owner, w_owner_nxt, r_ptr, w_ptr_nxt, w_owner_inc, w_proc_idx;
    logic [NUM_PROC-1:0]   r_gnt_proc, w_gnt_proc_nxt, w_proc_pick, w_req_eff;
    logic                  w_proc_valid, w_leave, w_force, r_busy;
    logic [c_SNP_W-1:0]    r_snp_owner, w_snp_owner_nxt, r_snp_ptr, w_snp_ptr_nxt;
    logic [c_SNP_W-1:0]    w_snp_owner_inc, w_snp_idx;
    logic [NUM_SNOOP-1:0]  r_gnt_snoop, w_gnt_snoop_nxt, w_snp_pick, w_snp_req_eff;
    logic                  w_snp_valid, r_snp_is_mem, w_snp_is_mem_nxt, r_gnt_mem, w_gnt_mem_nxt;

`ifdef ARB_TIMEOUT_EN
    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
    logic [c_HOLD_W-1:0]   r_hold, w_hold_nxt, w_hold_inc;
    // A timed-out owner stays locked out until it drops its request.
    logic [NUM_PROC-1:0]   r_blocked, w_blocked_nxt;
    logic                  r_timeout, w_timeout_nxt;

    assign w_hold_inc  = r_hold + 1'b1;
    assign w_force     = (r_state == GRANT) && (w_hold_inc == c_HOLD_W'(MAX_HOLD));
    assign w_req_eff   = Com_Bus_Req_proc & ~r_blocked;
    assign Arb_timeout = r_timeout;
`else
    assign w_force     = 1'b0;
    assign w_req_eff   = Com_Bus_Req_proc;
    assign Arb_timeout = 1'b0;
`endif

    assign w_leave = (r_state == GRANT) && (!Com_Bus_Req_proc[r_owner] || w_force);

    // The bus owner never competes for its own snoop slot.
    always_comb begin
        w_snp_req_eff = Com_Bus_Req_snoop;
        for (int i = 0; i < NUM_SNOOP; i++) begin
            if (int'(r_owner) == i) begin
                w_snp_req_eff[i] = 1'b0;
            end
        end
    end

    rr_picker #(.WIDTH(NUM_PROC), .PTR_W(c_PROC_W)) u_proc_pick (
        .req   (w_req_eff),
        .ptr   (r_ptr),
        .gnt   (w_proc_pick),
        .valid (w_proc_valid)
    );

    rr_picker #(.WIDTH(NUM_SNOOP), .PTR_W(c_SNP_W)) u_snoop_pick (
        .req   (w_snp_req_eff),
        .ptr   (r_snp_ptr),
        .gnt   (w_snp_pick),
        .valid (w_snp_valid)
    );

    assign w_proc_idx      = c_PROC_W'(onehot_to_idx(c_MAX_CH'(w_proc_pick)));
    assign w_snp_idx       = c_SNP_W'(onehot_to_idx(c_MAX_CH'(w_snp_pick)));
    assign w_owner_inc     = (r_owner == c_PROC_W'(NUM_PROC - 1)) ? '0 : r_owner + 1'b1;
    assign w_snp_owner_inc = (r_snp_owner == c_SNP_W'(NUM_SNOOP - 1)) ? '0 : r_snp_owner + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_ptr_nxt        = r_ptr;
        w_gnt_proc_nxt   = r_gnt_proc;
        w_snp_state_nxt  = r_snp_state;
        w_snp_owner_nxt  = r_snp_owner;
        w_snp_ptr_nxt    = r_snp_ptr;
        w_snp_is_mem_nxt = r_snp_is_mem;
        w_gnt_snoop_nxt  = r_gnt_snoop;
        w_gnt_mem_nxt    = r_gnt_mem;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt       = r_hold;
        w_timeout_nxt    = 1'b0;
        w_blocked_nxt    = r_blocked & Com_Bus_Req_proc;
`endif

        // Processor side
        case (r_state)
            IDLE: begin
                if (w_proc_valid) begin
                    w_state_nxt    = GRANT;
                    w_owner_nxt    = w_proc_idx;
                    w_gnt_proc_nxt = w_proc_pick;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt     = '0;
`endif
                end
            end
            GRANT: begin
                if (w_leave) begin
                    w_state_nxt    = RELEASE;
                    w_gnt_proc_nxt = '0;
`ifdef ARB_TIMEOUT_EN
                    if (w_force) begin
                        w_timeout_nxt          = 1'b1;
                        w_blocked_nxt[r_owner] = 1'b1;
                    end
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    w_hold_nxt = w_hold_inc;
                end
`endif
            end
            RELEASE: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = w_owner_inc;
            end
            default: begin
                w_state_nxt    = IDLE;
                w_gnt_proc_nxt = '0;
            end
        endcase

        // Snoop side: live only during a tenure that continues past this edge.
        if (r_state == GRANT && !w_leave) begin
            case (r_snp_state)
                IDLE: begin
                    if (w_snp_valid) begin
                        w_snp_state_nxt  = GRANT;
                        w_snp_owner_nxt  = w_snp_idx;
                        w_snp_is_mem_nxt = 1'b0;
                        w_gnt_snoop_nxt  = w_snp_pick;
                    end else if (Mem_snoop_req) begin
                        w_snp_state_nxt  = GRANT;
                        w_snp_is_mem_nxt = 1'b1;
                        w_gnt_mem_nxt    = 1'b1;
                    end
                end
                GRANT: begin
                    if (r_snp_is_mem ? !Mem_snoop_req : !Com_Bus_Req_snoop[r_snp_owner]) begin
                        w_snp_state_nxt = RELEASE;
                        w_gnt_snoop_nxt = '0;
                        w_gnt_mem_nxt   = 1'b0;
                    end
                end
                RELEASE: begin
                    w_snp_state_nxt = IDLE;
                    if (!r_snp_is_mem) begin
                        w_snp_ptr_nxt = w_snp_owner_inc;
                    end
                end
                default: begin
                    w_snp_state_nxt = IDLE;
                    w_gnt_snoop_nxt = '0;
                    w_gnt_mem_nxt   = 1'b0;
                end
            endcase
        end else begin
            w_snp_state_nxt = IDLE;
            w_gnt_snoop_nxt = '0;
            w_gnt_mem_nxt   = 1'b0;
            // A cut-short cache tenure still counts for fairness.
            if (r_snp_state != IDLE && !r_snp_is_mem) begin
                w_snp_ptr_nxt = w_snp_owner_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_gnt_proc   <= '0;
            r_busy       <= 1'b0;
            r_snp_state  <= IDLE;
            r_snp_owner  <= '0;
            r_snp_ptr    <= '0;
            r_snp_is_mem <= 1'b0;
            r_gnt_snoop  <= '0;
            r_gnt_mem    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_hold       <= '0;
            r_timeout    <= 1'b0;
            r_blocked    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_ptr        <= w_ptr_nxt;
            r_gnt_proc   <= w_gnt_proc_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_snp_state  <= w_snp_state_nxt;
            r_snp_owner  <= w_snp_owner_nxt;
            r_snp_ptr    <= w_snp_ptr_nxt;
            r_snp_is_mem <= w_snp_is_mem_nxt;
            r_gnt_snoop  <= w_gnt_snoop_nxt;
            r_gnt_mem    <= w_gnt_mem_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold       <= w_hold_nxt;
            r_timeout    <= w_timeout_nxt;
            r_blocked    <= w_blocked_nxt;
`endif
        end
    end

    assign Com_Bus_Gnt_proc  = r_gnt_proc;
    assign Com_Bus_Gnt_snoop = r_gnt_snoop;
    assign Mem_snoop_gnt     = r_gnt_mem;
    assign Arb_busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_com_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_com_bus_arbiter_rr
//  Purpose  : Scoreboard bench for com_bus_arbiter_rr. Stimulus pushes the
//             expected output vector for a given cycle; a negedge monitor
//             pops and compares. Covers reset, latency, async reset,
//             round-robin order, snoop priority, self-snoop masking and the
//             hold limit (ARB_TIMEOUT_EN) or unlimited hold (default).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_com_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_proc  = '0;
    logic [3:0] req_snoop = '0;
    logic       mem_req   = 1'b0;
    logic [7:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic       mem_gnt, busy, tmo;

    com_bus_arbiter_rr #(.NUM_PROC(8), .NUM_SNOOP(4), .MAX_HOLD(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .Com_Bus_Req_proc  (req_proc),
        .Com_Bus_Gnt_proc  (gnt_proc),
        .Com_Bus_Req_snoop (req_snoop),
        .Com_Bus_Gnt_snoop (gnt_snoop),
        .Mem_snoop_req     (mem_req),
        .Mem_snoop_gnt     (mem_gnt),
        .Arb_busy          (busy),
        .Arb_timeout       (tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [14:0] vec;   // {gnt_proc, gnt_snoop, mem_gnt, busy, timeout}
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic drain = 1'b0;
    exp_t cur;

    task automatic sb_push(input int c, input string nm, input logic [7:0] gp,
                           input logic [3:0] gs, input logic gm, input logic bz, input logic to);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.vec  = {gp, gs, gm, bz, to};
        sb.push_back(e);
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every expectation due by this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && (drain || sb[0].cyc <= cyc)) begin
            cur = sb.pop_front();
            total++;
            if (cur.cyc != cyc) begin
                bad++;
                $display("FAIL %s: check for cycle %0d not taken (now cycle %0d)", cur.name, cur.cyc, cyc);
            end else if ({gnt_proc, gnt_snoop, mem_gnt, busy, tmo} !== cur.vec) begin
                bad++;
                $display("FAIL %s @cyc %0d: got {gp,gs,gm,busy,to}=%h_%h_%b%b%b want %h_%h_%b%b%b",
                         cur.name, cyc, gnt_proc, gnt_snoop, mem_gnt, busy, tmo,
                         cur.vec[14:7], cur.vec[6:3], cur.vec[2], cur.vec[1], cur.vec[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, r, g, p, q, e;

        // Reset state
        goto_cyc(2);
        sb_push(2, "reset", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        sb_push(4, "idle_no_req", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);

        // Latency: proc5 alone
        goto_cyc(4);
        c0 = cyc;
        req_proc = 8'b0010_0000;
        sb_push(c0 + 1,  "lat_grant",    8'h20, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(c0 + 5,  "lat_hold",     8'h20, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(c0 + 11, "lat_gnt_off",  8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(c0 + 12, "lat_busy_off", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        goto_cyc(c0 + 10);
        req_proc = '0;

        // Async reset mid-tenure with proc3 as owner (ptr is 6 here)
        r = c0 + 13;
        goto_cyc(r);
        req_proc = 8'h08;
        sb_push(r + 1, "rst_owner3", 8'h08, 4'h0, 1'b0, 1'b1, 1'b0);
        goto_cyc(r + 3);
        #2;
        rst = 1'b1;
        sb_push(r + 3, "rst_async", 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        req_proc = 8'hFF;
        sb_push(r + 4, "rst_held",  8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        goto_cyc(r + 5);
        rst = 1'b0;

        // Round-robin: all requesting, 4-cycle tenures, order 0..7,0
        g = r + 6;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] oh;
            oh = 8'(1 << (k % 8));
            sb_push(g,     "rr_grant",   oh,    4'h0, 1'b0, 1'b1, 1'b0);
            sb_push(g + 3, "rr_hold",    oh,    4'h0, 1'b0, 1'b1, 1'b0);
            sb_push(g + 4, "rr_release", 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
            sb_push(g + 5, "rr_idle",    8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
            goto_cyc(g + 3);
            if (k == 8) req_proc = '0;
            else        req_proc = req_proc & ~oh;
            goto_cyc(g + 4);
            if (k != 8) req_proc = req_proc | oh;
            g = g + 6;
        end

        // Snoop priority: proc2 owner, cache1 and memory together
        goto_cyc(g);
        p = cyc;
        req_proc = 8'h04;
        sb_push(p + 1, "snp_owner", 8'h04, 4'h0, 1'b0, 1'b1, 1'b0);
        goto_cyc(p + 1);
        req_snoop = 4'b0010;
        mem_req   = 1'b1;
        sb_push(p + 2,  "snp_cache_first", 8'h04, 4'b0010, 1'b0, 1'b1, 1'b0);
        sb_push(p + 4,  "snp_cache_hold",  8'h04, 4'b0010, 1'b0, 1'b1, 1'b0);
        sb_push(p + 6,  "snp_release",     8'h04, 4'h0,    1'b0, 1'b1, 1'b0);
        sb_push(p + 7,  "snp_dead",        8'h04, 4'h0,    1'b0, 1'b1, 1'b0);
        sb_push(p + 8,  "snp_mem",         8'h04, 4'h0,    1'b1, 1'b1, 1'b0);
        sb_push(p + 11, "snp_force_clear", 8'h00, 4'h0,    1'b0, 1'b1, 1'b0);
        goto_cyc(p + 5);
        req_snoop = '0;
        goto_cyc(p + 10);
        req_proc = '0;
        goto_cyc(p + 11);
        mem_req = 1'b0;

        // Self-snoop masked: proc1 owner, cache1 request ignored
        q = p + 12;
        goto_cyc(q);
        req_proc = 8'h02;
        sb_push(q + 1, "self_owner", 8'h02, 4'h0, 1'b0, 1'b1, 1'b0);
        goto_cyc(q + 1);
        req_snoop = 4'b0010;
        sb_push(q + 2, "self_masked",  8'h02, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(q + 3, "self_masked2", 8'h02, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(q + 4, "self_mem",     8'h02, 4'h0, 1'b1, 1'b1, 1'b0);
        sb_push(q + 7, "self_release", 8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(q + 8, "self_idle",    8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        goto_cyc(q + 3);
        mem_req = 1'b1;
        goto_cyc(q + 6);
        req_proc  = '0;
        req_snoop = '0;
        mem_req   = 1'b0;

        // Long hold by proc4 with proc5 waiting (ptr is 2 here)
        goto_cyc(q + 8);
        req_proc = 8'h30;
        e = q + 9;
`ifdef ARB_TIMEOUT_EN
        sb_push(e,      "to_grant4",   8'h10, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 15, "to_last",     8'h10, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 16, "to_pulse",    8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
        sb_push(e + 17, "to_once",     8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        sb_push(e + 18, "to_next5",    8'h20, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 21, "to_rel5",     8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 23, "to_blocked",  8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        sb_push(e + 33, "to_reraise",  8'h10, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 36, "to_end",      8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        goto_cyc(e + 20);
        req_proc = 8'h10;
        goto_cyc(e + 30);
        req_proc = '0;
        goto_cyc(e + 32);
        req_proc = 8'h10;
        goto_cyc(e + 34);
        req_proc = '0;
        goto_cyc(e + 38);
`else
        sb_push(e,      "hold_grant4",     8'h10, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 16, "hold_no_timeout", 8'h10, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 25, "hold_long",       8'h10, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 26, "hold_rel",        8'h00, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 28, "hold_next5",      8'h20, 4'h0, 1'b0, 1'b1, 1'b0);
        sb_push(e + 32, "hold_end",        8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
        goto_cyc(e + 25);
        req_proc = 8'h20;
        goto_cyc(e + 30);
        req_proc = '0;
        goto_cyc(e + 34);
`endif

        // Anything still queued is reported by the monitor as not taken.
        drain = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
